switch_pair_debounce: RTL and testbench

- Upstream conditioning stage for the two-switch XOR/LED logic on the Vaman board.
- Takes two raw, asynchronous, bouncing switch inputs and synchronises each to clk.
- Debounces each channel independently and presents clean levels X_db/Y_db that feed the XOR-to-LED stage directly.
- Also flags per-channel change events and a combined "settled" status.

---
 rtl/switch_pair_debounce.sv | 111 +++++++++++
 tb/tb_switch_pair_debounce.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/switch_pair_debounce.sv
// Two-channel switch conditioner: 2-flop synchroniser plus per-channel debounce FSM.
// Build option: define DEBOUNCE_ONE_SHOT_EN to report only rising (press) transitions on X_chg/Y_chg.
module switch_pair_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 240000,
    parameter logic        RESET_LEVEL     = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic X_raw,
    input  logic Y_raw,
    output logic X_db,
    output logic Y_db,
    output logic X_chg,
    output logic Y_chg,
    output logic settled
);

    localparam int unsigned     CW       = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
`ifdef DEBOUNCE_ONE_SHOT_EN
    localparam logic            ONE_SHOT = 1'b1;
`else
    localparam logic            ONE_SHOT = 1'b0;
`endif

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

    // Index 0 is the X channel, index 1 is the Y channel.
    logic [1:0]    sync1_r;
    logic [1:0]    sync2_r;
    logic [1:0]    db_r;
    logic [1:0]    chg_r;
    logic          settled_r;
    state_t        state_r [2];
    logic [CW-1:0] cnt_r   [2];
    logic [1:0]    next_idle_s;

    // Predict which channels will be IDLE after this edge so settled lines up with db.
    always_comb begin
        next_idle_s = 2'b00;
        for (int i = 0; i < 2; i++) begin
            if (state_r[i] == IDLE) begin
                next_idle_s[i] = (sync2_r[i] == db_r[i]);
            end else begin
                next_idle_s[i] = (sync2_r[i] == db_r[i]) || (cnt_r[i] == CNT_LAST);
            end
        end
    end

    // Synchronisers, both debounce FSMs and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_r    <= {2{RESET_LEVEL}};
            sync2_r    <= {2{RESET_LEVEL}};
            db_r       <= {2{RESET_LEVEL}};
            chg_r      <= 2'b00;
            settled_r  <= 1'b1;
            state_r[0] <= IDLE;
            state_r[1] <= IDLE;
            cnt_r[0]   <= {CW{1'b0}};
            cnt_r[1]   <= {CW{1'b0}};
        end else begin
            sync1_r   <= {Y_raw, X_raw};
            sync2_r   <= sync1_r;
            settled_r <= &next_idle_s;
            for (int i = 0; i < 2; i++) begin
                chg_r[i] <= 1'b0;
                case (state_r[i])
                    IDLE: begin
                        cnt_r[i] <= {CW{1'b0}};
                        if (sync2_r[i] != db_r[i]) begin
                            state_r[i] <= COUNT;
                            cnt_r[i]   <= CW'(1);
                        end else begin
                            state_r[i] <= IDLE;
                        end
                    end
                    COUNT: begin
                        // A return to the accepted level wins even on the final count cycle.
                        if (sync2_r[i] == db_r[i]) begin
                            state_r[i] <= IDLE;
                            cnt_r[i]   <= {CW{1'b0}};
                        end else if (cnt_r[i] == CNT_LAST) begin
                            db_r[i]    <= sync2_r[i];
                            chg_r[i]   <= ~ONE_SHOT | sync2_r[i];
                            state_r[i] <= IDLE;
                            cnt_r[i]   <= {CW{1'b0}};
                        end else begin
                            state_r[i] <= COUNT;
                            cnt_r[i]   <= cnt_r[i] + CW'(1);
                        end
                    end
                    default: begin
                        state_r[i] <= IDLE;
                        cnt_r[i]   <= {CW{1'b0}};
                    end
                endcase
            end
        end
    end

    assign X_db    = db_r[0];
    assign Y_db    = db_r[1];
    assign X_chg   = chg_r[0];
    assign Y_chg   = chg_r[1];
    assign settled = settled_r;

endmodule

// File: tb/tb_switch_pair_debounce.sv
// Scoreboard bench for switch_pair_debounce: a run-length reference model predicts every cycle,
// plus directed latency/boundary checks and randomised switch activity.
module tb_switch_pair_debounce;

    localparam int DC = 8;
`ifdef DEBOUNCE_ONE_SHOT_EN
    localparam bit ONE_SHOT = 1'b1;
`else
    localparam bit ONE_SHOT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    logic X_raw, Y_raw;
    logic X_db, Y_db, X_chg, Y_chg, settled;

    int vectors     = 0;
    int miscompares = 0;

    // Expected {X_db, Y_db, X_chg, Y_chg, settled}, one entry per active clock edge.
    logic [4:0] exp_q[$];

    // Reference model state: raw-sample delay line, accepted level, mismatch run length.
    bit m_s1 [2];
    bit m_s2 [2];
    bit m_db [2];
    bit m_chg[2];
    int m_run[2];

    switch_pair_debounce #(
        .DEBOUNCE_CYCLES(DC),
        .RESET_LEVEL    (1'b0)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .X_raw  (X_raw),
        .Y_raw  (Y_raw),
        .X_db   (X_db),
        .Y_db   (Y_db),
        .X_chg  (X_chg),
        .Y_chg  (Y_chg),
        .settled(settled)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: a level is accepted once it has differed from the accepted level for DC consecutive edges.
    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                for (int c = 0; c < 2; c++) begin
                    m_s1[c] = 1'b0; m_s2[c] = 1'b0; m_db[c] = 1'b0;
                    m_chg[c] = 1'b0; m_run[c] = 0;
                end
                exp_q.delete();
            end else begin
                for (int c = 0; c < 2; c++) begin
                    m_chg[c] = 1'b0;
                    if (m_s2[c] != m_db[c]) begin
                        m_run[c] = m_run[c] + 1;
                        if (m_run[c] == DC) begin
                            m_db[c]  = m_s2[c];
                            m_chg[c] = !ONE_SHOT || m_s2[c];
                            m_run[c] = 0;
                        end
                    end else begin
                        m_run[c] = 0;
                    end
                end
                m_s2[0] = m_s1[0]; m_s1[0] = X_raw;
                m_s2[1] = m_s1[1]; m_s1[1] = Y_raw;
                exp_q.push_back({m_db[0], m_db[1], m_chg[0], m_chg[1],
                                 (m_run[0] == 0) && (m_run[1] == 0)});
            end
        end
    end

    // Monitor: outputs are valid every cycle out of reset; compare away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && exp_q.size() != 0) begin
                check("scoreboard", {X_db, Y_db, X_chg, Y_chg, settled}, exp_q.pop_front());
            end
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // Step X to lvl and check the exact edge of acceptance relative to the first sampling edge.
    task automatic step_x(input bit lvl, input bit exp_pulse);
        @(negedge clk);
        X_raw = lvl;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("x_step", {2'b00, X_db, X_chg, settled},
                  {2'b00, (n >= DC + 1) ? lvl : !lvl, (n == DC + 1) && exp_pulse,
                   !((n >= 2) && (n <= DC))});
        end
    endtask

    int hold_x, hold_y;

    initial begin
        rst_n = 1'b1;
        X_raw = 1'b0;
        Y_raw = 1'b0;
        #1 rst_n = 1'b0;
        #1 check("reset_state", {X_db, Y_db, X_chg, Y_chg, settled}, 5'b00001);
        idle(3);
        rst_n = 1'b1;
        idle(4);

        // Clean press and release of X.
        step_x(1'b1, 1'b1);
        idle(3);
        step_x(1'b0, !ONE_SHOT);
        idle(3);

        // Bouncing press on X, then let it go.
        for (int b = 0; b < 4; b++) begin
            X_raw = (b % 2 == 0);
            idle(3);
        end
        X_raw = 1'b1;
        idle(15);
        X_raw = 1'b0;
        idle(15);

        // Y burst ending exactly on the final count cycle, then a real hold.
        Y_raw = 1'b1;
        idle(DC - 1);
        Y_raw = 1'b0;
        idle(1);
        Y_raw = 1'b1;
        idle(15);
        Y_raw = 1'b0;
        idle(15);

        // Simultaneous step on both channels.
        @(negedge clk);
        X_raw = 1'b1;
        Y_raw = 1'b1;
        for (int n = 0; n < 12; n++) begin
            @(posedge clk);
            @(negedge clk);
            check("simultaneous", {1'b0, X_db ^ Y_db, X_chg, Y_chg, X_db},
                  {1'b0, 1'b0, n == DC + 1, n == DC + 1, n >= DC + 1});
        end
        X_raw = 1'b0;
        Y_raw = 1'b0;
        idle(15);

        // Asynchronous reset in the middle of an X count.
        X_raw = 1'b1;
        idle(5);
        #2 rst_n = 1'b0;
        #1 check("reset_midcount", {X_db, Y_db, X_chg, Y_chg, settled}, 5'b00001);
        idle(3);
        rst_n = 1'b1;
        idle(15);
        X_raw = 1'b0;
        idle(15);

        // Randomised independent switch activity.
        hold_x = 0;
        hold_y = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (hold_x == 0) begin
                X_raw  = $urandom_range(0, 1);
                hold_x = $urandom_range(1, 14);
            end
            if (hold_y == 0) begin
                Y_raw  = $urandom_range(0, 1);
                hold_y = $urandom_range(1, 14);
            end
            hold_x--;
            hold_y--;
        end
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
